// File: rtl/if_id_buffer_pkg.sv
// Constants shared by fetch, the IF/ID buffer and decode so all three agree on
// the instruction word layout, the bubble instruction and the boot PC.
package if_id_buffer_pkg;

    localparam int WORD_W = 32;
    localparam int DROP_W = 16;

    // sll $0,$0,0 -- the bubble decode sees while nothing is buffered
    localparam logic [WORD_W-1:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_3000;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_buffer_fifo_mem.sv
// Generic DEPTH x WIDTH register array: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module if_id_buffer_fifo_mem #(
    parameter int DEPTH = 2,
    parameter int AW    = 1,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_buffer.sv
// Decoupling buffer between fetch and decode: holds {instr, PC} pairs in order,
// backpressures fetch through in_ready and drops wrong-path entries on flush.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [WORD_W-1:0] NOP      = NOP_INSTR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_W-1:0]       in_instr,
    input  logic [WORD_W-1:0]       in_pc,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_W-1:0]       out_instr,
    output logic [WORD_W-1:0]       out_pc,
    output logic [WORD_W-1:0]       out_pc8,
    output logic [$clog2(DEPTH):0]  count,
    output logic [DROP_W-1:0]       drop_cnt
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             CNT_W    = AW + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] acc,
                                                       input logic [CNT_W-1:0]  inc);
        logic [DROP_W:0] sum;
        sum = {1'b0, acc} + (DROP_W + 1)'(inc);
        return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
    endfunction

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              push, pop;
    fetch_entry_t      wr_entry, rd_entry;

    // Handshakes depend only on registered occupancy, never on out_ready,
    // so a pop while full cannot open the door for a same-cycle push.
    assign out_valid = (count_q != '0);
    assign in_ready  = (count_q != FULL_CNT);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign wr_entry.instr = in_instr;
    assign wr_entry.pc    = in_pc;

    if_id_buffer_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH ($bits(fetch_entry_t))
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            drop_d   = sat_add_drop(drop_q, count_q);
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is never cleared, so an empty buffer must mask it with the bubble
    assign out_instr = out_valid ? rd_entry.instr : NOP;
    assign out_pc    = out_valid ? rd_entry.pc    : RESET_PC;
    assign out_pc8   = out_pc + 32'd8;
    assign count     = count_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: queue model checked every cycle plus directed
// literal expectations; a deep second instance drives drop_cnt into saturation.
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_instr, out_pc, out_pc8;
    logic [1:0]  count;
    logic [15:0] drop_cnt;

    logic        s_rst = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0, s_flush = 1'b0;
    logic [31:0] s_in_instr = '0, s_in_pc = '0;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_instr, s_out_pc, s_out_pc8;
    logic [8:0]  s_count;
    logic [15:0] s_drop_cnt;
    logic        sat_done = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    if_id_buffer #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc8(out_pc8), .count(count), .drop_cnt(drop_cnt)
    );

    if_id_buffer #(.DEPTH(256)) u_sat (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_instr(s_in_instr), .in_pc(s_in_pc), .flush(s_flush),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_instr(s_out_instr),
        .out_pc(s_out_pc), .out_pc8(s_out_pc8), .count(s_count), .drop_cnt(s_drop_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: an in-order queue of {instr, pc} and a drop tally
    logic [63:0] mq[$];
    int          mdrop = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mdrop = 0;
        end else if (flush) begin
            mdrop = (mdrop + mq.size() > 65535) ? 65535 : mdrop + mq.size();
            mq.delete();
        end else begin
            logic was_full, was_empty;
            was_full  = (mq.size() == 2);
            was_empty = (mq.size() == 0);
            if (!was_empty && out_ready) void'(mq.pop_front());
            if (in_valid && !was_full) mq.push_back({in_instr, in_pc});
        end
    end

    always @(negedge clk) begin
        logic [31:0] e_instr, e_pc;
        e_instr = (mq.size() != 0) ? mq[0][63:32] : 32'h0000_0000;
        e_pc    = (mq.size() != 0) ? mq[0][31:0]  : 32'h0000_3000;
        chk("m_out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
        chk("m_in_ready",  {31'd0, in_ready},  {31'd0, mq.size() != 2});
        chk("m_count",     {30'd0, count},     32'(mq.size()));
        chk("m_out_instr", out_instr, e_instr);
        chk("m_out_pc",    out_pc,    e_pc);
        chk("m_out_pc8",   out_pc8,   e_pc + 32'd8);
        chk("m_drop_cnt",  {16'd0, drop_cnt}, 32'(mdrop));
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        @(negedge clk);
    endtask

    // Deep instance: 256 rounds of fill-256-then-flush push drop_cnt past 16'hFFFF
    initial begin : sat_run
        int sexp;
        sexp = 0;
        #1 s_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        s_rst = 1'b0;
        for (int r = 0; r < 257; r++) begin
            int n;
            n = (r == 256) ? 1 : 256;
            s_flush = 1'b0;
            for (int i = 0; i < n; i++) begin
                s_in_valid = 1'b1; s_in_instr = 32'(i); s_in_pc = 32'h3000 + 32'(4 * i);
                @(negedge clk);
            end
            if (r == 0) begin
                chk("sat_count_full", {23'd0, s_count}, 32'd256);
                chk("sat_in_ready_full", {31'd0, s_in_ready}, 32'd0);
            end
            s_flush = 1'b1;
            @(negedge clk);
            sexp = (sexp + n > 65535) ? 65535 : sexp + n;
            chk("sat_drop_model", {16'd0, s_drop_cnt}, 32'(sexp));
            if (r == 0)   chk("sat_drop_256",  {16'd0, s_drop_cnt}, 32'd256);
            if (r == 254) chk("sat_drop_ff00", {16'd0, s_drop_cnt}, 32'h0000_FF00);
            if (r == 255) chk("sat_drop_clamp", {16'd0, s_drop_cnt}, 32'h0000_FFFF);
            if (r == 256) chk("sat_drop_hold", {16'd0, s_drop_cnt}, 32'h0000_FFFF);
        end
        s_flush = 1'b0; s_in_valid = 1'b0;
        chk("sat_count_after", {23'd0, s_count}, 32'd0);
        sat_done = 1'b1;
    end

    initial begin : main_run
        bit ok;
        // Reset raised between edges must show the empty outputs at once
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_instr", out_instr, 32'h0000_0000);
        chk("rst_out_pc",    out_pc,    32'h0000_3000);
        chk("rst_out_pc8",   out_pc8,   32'h0000_3008);
        chk("rst_count",     {30'd0, count}, 32'd0);
        chk("rst_drop",      {16'd0, drop_cnt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fill and stall
        step(1, 32'h2401_0001, 32'h3000, 0, 0);
        chk("fill1_head", out_instr, 32'h2401_0001);
        step(1, 32'h2402_0002, 32'h3004, 0, 0);
        chk("fill_count", {30'd0, count}, 32'd2);
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
        step(1, 32'hDEAD_BEEF, 32'h3008, 0, 0);
        chk("stall_count", {30'd0, count}, 32'd2);
        chk("stall_head_instr", out_instr, 32'h2401_0001);
        chk("stall_head_pc", out_pc, 32'h0000_3000);
        step(0, 32'h0, 32'h0, 1, 0);
        chk("drain_head_pc", out_pc, 32'h0000_3004);
        step(0, 32'h0, 32'h0, 1, 0);
        chk("drain_empty", {31'd0, out_valid}, 32'd0);

        // Streaming: one in, one out per cycle
        step(1, 32'h2000_0000, 32'h3000, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            step(1, 32'h2000_0000 + 32'(k), 32'h3000 + 32'(4 * k), 1, 0);
            chk("stream_count", {30'd0, count}, 32'd1);
            chk("stream_pc", out_pc, 32'h3000 + 32'(4 * k));
            chk("stream_pc8", out_pc8, 32'h3008 + 32'(4 * k));
        end
        step(0, 32'h0, 32'h0, 1, 0);

        // Full with simultaneous pop: pop only, push next cycle
        step(1, 32'hA000_0001, 32'h3200, 0, 0);
        step(1, 32'hA000_0002, 32'h3204, 0, 0);
        step(1, 32'hA000_0003, 32'h3208, 1, 0);
        chk("fullpop_count", {30'd0, count}, 32'd1);
        chk("fullpop_head", out_pc, 32'h0000_3204);
        step(1, 32'hA000_0003, 32'h3208, 0, 0);
        chk("fullpop_push", {30'd0, count}, 32'd2);

        // Flush with push and pop in the same cycle
        step(1, 32'hB000_0000, 32'h320C, 1, 1);
        chk("flush_count", {30'd0, count}, 32'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_drop", {16'd0, drop_cnt}, 32'd2);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        step(1, 32'h0800_0c00, 32'h3100, 0, 0);
        chk("postflush_instr", out_instr, 32'h0800_0c00);
        chk("postflush_pc", out_pc, 32'h0000_3100);
        step(0, 32'h0, 32'h0, 1, 0);
        step(1, 32'hC000_0000, 32'h3300, 0, 1);
        chk("flush_empty_drop", {16'd0, drop_cnt}, 32'd2);
        chk("flush_empty_count", {30'd0, count}, 32'd0);

        // Ten entries streamed through, wrapping both pointers
        for (int k = 0; k < 10; k++) begin
            step(1, 32'h1000_0000 + 32'(k), 32'h4000 + 32'(4 * k), 1, 0);
        end
        chk("wrap_head_pc", out_pc, 32'h0000_4024);
        chk("wrap_head_instr", out_instr, 32'h1000_0009);
        step(0, 32'h0, 32'h0, 1, 0);
        chk("wrap_drained", {30'd0, count}, 32'd0);

        // Reset mid-operation loses the buffered entries and the drop tally
        step(1, 32'hE000_0001, 32'h5000, 0, 0);
        step(1, 32'hE000_0002, 32'h5004, 0, 0);
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("midrst_count", {30'd0, count}, 32'd0);
        chk("midrst_pc", out_pc, 32'h0000_3000);
        chk("midrst_drop", {16'd0, drop_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 32'h0, 32'h0, 0, 0);

        ok = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            if (sat_done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("sat_finished", {31'd0, ok}, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
